// File: rtl/spell_sram_wb_bridge_pkg.sv
// Shared constants for the spell SRAM bridge: FSM state encodings and OpenRAM geometry.
// Imported by the bridge; the state enum takes its values from the 3-bit constants.
package spell_sram_wb_bridge_pkg;

  localparam int SramAddrWidth = 8;
  localparam int SramDataWidth = 32;
  localparam int SramMaskWidth = SramDataWidth / 8;

  localparam logic [2:0] SramStIdle   = 3'd0;
  localparam logic [2:0] SramStAccess = 3'd1;
  localparam logic [2:0] SramStWait   = 3'd2;
  localparam logic [2:0] SramStAck    = 3'd3;
  localparam logic [2:0] SramStTurn   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = SramStIdle,
    ST_ACCESS = SramStAccess,
    ST_WAIT   = SramStWait,
    ST_ACK    = SramStAck,
    ST_TURN   = SramStTurn
  } sram_state_e;

endpackage

// File: rtl/spell_sram_wb_bridge.sv
// Wishbone-classic slave to OpenRAM port 0; write ack at +2, read ack at +2+READ_LATENCY.
// No backpressure beyond classic handshake: one transfer per (ack cycle + 2), a TURN idle cycle after every ack.
module spell_sram_wb_bridge
  import spell_sram_wb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH   = SramAddrWidth,
  parameter int DATA_WIDTH   = SramDataWidth,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    ram_csb0,
  output logic                    ram_web0,
  output logic [DATA_WIDTH/8-1:0] ram_wmask0,
  output logic [ADDR_WIDTH-1:0]   ram_addr0,
  output logic [DATA_WIDTH-1:0]   ram_din0,
  input  logic [DATA_WIDTH-1:0]   ram_dout0
);

  localparam int         MaskWidth = DATA_WIDTH / 8;
  localparam logic [1:0] LatInit   = 2'(READ_LATENCY - 1);

  sram_state_e           state, state_nxt;
  logic [1:0]            lat_cnt, lat_cnt_nxt;
  logic                  we_q, we_nxt;
  logic                  req;
  logic                  csb_nxt, web_nxt, ack_nxt;
  logic [MaskWidth-1:0]  wmask_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] din_nxt, dat_nxt;

  assign req = wb_cyc_i & wb_stb_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      we_q       <= 1'b0;
      ram_csb0   <= 1'b1;
      ram_web0   <= 1'b1;
      ram_wmask0 <= '0;
      ram_addr0  <= '0;
      ram_din0   <= '0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      we_q       <= we_nxt;
      ram_csb0   <= csb_nxt;
      ram_web0   <= web_nxt;
      ram_wmask0 <= wmask_nxt;
      ram_addr0  <= addr_nxt;
      ram_din0   <= din_nxt;
      wb_ack_o   <= ack_nxt;
      wb_dat_o   <= dat_nxt;
    end
  end

  // Address/data/mask registers double as the request latch; only csb/web return to idle.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    we_nxt      = we_q;
    csb_nxt     = 1'b1;
    web_nxt     = 1'b1;
    wmask_nxt   = ram_wmask0;
    addr_nxt    = ram_addr0;
    din_nxt     = ram_din0;
    ack_nxt     = 1'b0;
    dat_nxt     = wb_dat_o;
    case (state)
      ST_IDLE: begin
        if (req) begin
          we_nxt    = wb_we_i;
          csb_nxt   = 1'b0;
          web_nxt   = ~wb_we_i;
          addr_nxt  = wb_adr_i;
          din_nxt   = wb_dat_i;
          wmask_nxt = wb_we_i ? wb_sel_i : '0;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!wb_cyc_i) begin
          state_nxt = ST_TURN;
        end else if (we_q) begin
          ack_nxt   = 1'b1;
          state_nxt = ST_ACK;
        end else begin
          lat_cnt_nxt = LatInit;
          state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An abort lets the RAM read finish but drops its data.
        if (!wb_cyc_i) begin
          state_nxt = ST_TURN;
        end else if (lat_cnt == 2'd0) begin
          dat_nxt   = ram_dout0;
          ack_nxt   = 1'b1;
          state_nxt = ST_ACK;
        end else begin
          lat_cnt_nxt = lat_cnt - 2'd1;
        end
      end
      ST_ACK:  state_nxt = ST_TURN;
      ST_TURN: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spell_sram_wb_bridge.sv
// Directed scoreboard bench for spell_sram_wb_bridge: a READ_LATENCY=1 and a READ_LATENCY=3
// instance, each with its own behavioural OpenRAM model, driven one at a time through a shared master.
module tb_spell_sram_wb_bridge;

  typedef struct {
    int          ack_cyc;
    bit          rd;
    logic [31:0] dat;
  } exp_t;

  logic        clock, reset;
  logic        m_cyc, m_stb, m_we, tgt3;
  logic [3:0]  m_sel;
  logic [7:0]  m_adr;
  logic [31:0] m_dat;

  logic        cyc1, cyc3;
  logic [31:0] dat_o1, dat_o3, din1, din3, dout1, dout3;
  logic        ack1, ack3, csb1, csb3, web1, web3;
  logic [3:0]  wmask1, wmask3;
  logic [7:0]  addr1, addr3;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  logic        obs_ack, obs_csb, obs_web;
  logic [31:0] obs_dat, obs_din;
  logic [3:0]  obs_wmask;
  logic [7:0]  obs_addr;

  int   errors, checks, cycle_cnt, ack_cnt, t0, a0;
  exp_t sb[$];
  int   csb_low_q[$];

  assign cyc1 = m_cyc & ~tgt3;
  assign cyc3 = m_cyc & tgt3;

  assign obs_ack   = tgt3 ? ack3   : ack1;
  assign obs_csb   = tgt3 ? csb3   : csb1;
  assign obs_web   = tgt3 ? web3   : web1;
  assign obs_dat   = tgt3 ? dat_o3 : dat_o1;
  assign obs_din   = tgt3 ? din3   : din1;
  assign obs_wmask = tgt3 ? wmask3 : wmask1;
  assign obs_addr  = tgt3 ? addr3  : addr1;

  spell_sram_wb_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .wb_cyc_i(cyc1), .wb_stb_i(m_stb), .wb_we_i(m_we), .wb_sel_i(m_sel),
    .wb_adr_i(m_adr), .wb_dat_i(m_dat), .wb_dat_o(dat_o1), .wb_ack_o(ack1),
    .ram_csb0(csb1), .ram_web0(web1), .ram_wmask0(wmask1), .ram_addr0(addr1),
    .ram_din0(din1), .ram_dout0(dout1)
  );

  spell_sram_wb_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .wb_cyc_i(cyc3), .wb_stb_i(m_stb), .wb_we_i(m_we), .wb_sel_i(m_sel),
    .wb_adr_i(m_adr), .wb_dat_i(m_dat), .wb_dat_o(dat_o3), .wb_ack_o(ack3),
    .ram_csb0(csb3), .ram_web0(web3), .ram_wmask0(wmask3), .ram_addr0(addr3),
    .ram_din0(din3), .ram_dout0(dout3)
  );

  // Behavioural OpenRAM port 0: cycle captured on the clock edge, read data held until the next read.
  always @(posedge clock) begin
    if (!csb1) begin
      if (!web1) begin
        for (int b = 0; b < 4; b++)
          if (wmask1[b]) mem1[addr1][8*b +: 8] <= din1[8*b +: 8];
      end else begin
        dout1 <= mem1[addr1];
      end
    end
  end

  always @(posedge clock) begin
    if (!csb3) begin
      if (!web3) begin
        for (int b = 0; b < 4; b++)
          if (wmask3[b]) mem3[addr3][8*b +: 8] <= din3[8*b +: 8];
      end else begin
        dout3 <= mem3[addr3];
      end
    end
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock; samples the selected instance 1 time unit after the edge and retires acks.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cycle_cnt++;
    if (obs_csb === 1'b0) csb_low_q.push_back(cycle_cnt);
    if (obs_ack === 1'b1) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(obs_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", 32'(cycle_cnt), 32'(e.ack_cyc));
        if (e.rd) chk("rd_data", obs_dat, e.dat);
      end
    end
  endtask

  task automatic start(input bit we, input logic [3:0] sel, input logic [7:0] adr,
                       input logic [31:0] dat, input int lat, input bit push,
                       input logic [31:0] exp_dat);
    exp_t e;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_dat = dat;
    t0 = cycle_cnt;
    if (push) begin
      e.ack_cyc = we ? t0 + 2 : t0 + 2 + lat;
      e.rd      = !we;
      e.dat     = exp_dat;
      sb.push_back(e);
    end
  endtask

  // Scrambles the bus after the sample cycle, waits (bounded) for the ack, then idles through TURN.
  task automatic finish_xfer();
    m_stb = 1'b0; m_adr = 8'h77; m_dat = 32'h0; m_sel = 4'h0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    chk("ack_seen", 32'(sb.size()), 32'd0);
    m_cyc = 1'b0;
    tick();
    tick();
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    start(1'b1, sel, adr, dat, 0, 1'b1, 32'h0);
    tick();
    finish_xfer();
  endtask

  task automatic rd(input logic [7:0] adr, input int lat, input logic [31:0] expv);
    start(1'b0, 4'hF, adr, 32'h0, lat, 1'b1, expv);
    tick();
    finish_xfer();
  endtask

  initial begin
    errors = 0; checks = 0; cycle_cnt = 0; ack_cnt = 0;
    reset = 1'b1; tgt3 = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = 4'h0; m_adr = 8'h0; m_dat = 32'h0;
    tick();
    tick();

    chk("rst_csb", 32'(csb1), 32'd1);
    chk("rst_web", 32'(web1), 32'd1);
    chk("rst_wmask", 32'(wmask1), 32'd0);
    chk("rst_addr", 32'(addr1), 32'd0);
    chk("rst_din", din1, 32'd0);
    chk("rst_ack", 32'(ack1), 32'd0);
    chk("rst_dat", dat_o1, 32'd0);
    chk("rst_csb3", 32'(csb3), 32'd1);
    reset = 1'b0;
    tick();

    // Full-word write: ACCESS-cycle RAM pins, then a single ack
    start(1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 0, 1'b1, 32'h0);
    tick();
    chk("wr_csb", 32'(obs_csb), 32'd0);
    chk("wr_web", 32'(obs_web), 32'd0);
    chk("wr_wmask", 32'(obs_wmask), 32'hF);
    chk("wr_addr", 32'(obs_addr), 32'h05);
    chk("wr_din", obs_din, 32'hDEADBEEF);
    a0 = ack_cnt;
    tick();
    chk("wr_ack_once", 32'(ack_cnt - a0), 32'd1);
    chk("wr_csb_idle", 32'(obs_csb), 32'd1);
    chk("wr_web_idle", 32'(obs_web), 32'd1);
    m_cyc = 1'b0; m_stb = 1'b0;
    tick();
    chk("wr_ack_drop", 32'(obs_ack), 32'd0);
    tick();

    // Byte-lane write and full-word readback
    wr(8'h05, 32'h11111111, 4'h4);
    start(1'b0, 4'hF, 8'h05, 32'h0, 1, 1'b1, 32'hDE11BEEF);
    tick();
    chk("rd_csb", 32'(obs_csb), 32'd0);
    chk("rd_web", 32'(obs_web), 32'd1);
    chk("rd_wmask", 32'(obs_wmask), 32'd0);
    finish_xfer();

    // Zero-mask write is acked but changes nothing; read data holds across writes
    wr(8'h05, 32'h00000000, 4'h0);
    chk("dat_hold_wr", obs_dat, 32'hDE11BEEF);
    rd(8'h05, 1, 32'hDE11BEEF);

    // READ_LATENCY=3 instance
    tgt3 = 1'b1;
    tick();
    wr(8'hFF, 32'h12345678, 4'hF);
    csb_low_q.delete();
    start(1'b0, 4'hF, 8'hFF, 32'h0, 3, 1'b1, 32'h12345678);
    tick();
    finish_xfer();
    chk("l3_csb_cnt", 32'(csb_low_q.size()), 32'd1);
    chk("l3_csb_cyc", 32'(csb_low_q[0]), 32'(t0 + 1));

    // Abort during WAIT: no ack, read data unchanged
    a0 = ack_cnt;
    start(1'b0, 4'hF, 8'h05, 32'h0, 3, 1'b0, 32'h0);
    tick();
    tick();
    m_cyc = 1'b0; m_stb = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("abort_dat", obs_dat, 32'h12345678);

    // Back-to-back writes with stb held on the RL=1 instance
    tgt3 = 1'b0;
    tick();
    a0 = ack_cnt;
    csb_low_q.delete();
    start(1'b1, 4'hF, 8'h20, 32'hA5A5A5A5, 0, 1'b1, 32'h0);
    begin
      exp_t e2;
      e2.ack_cyc = t0 + 6; e2.rd = 1'b0; e2.dat = 32'h0;
      sb.push_back(e2);
    end
    tick();
    m_adr = 8'h21; m_dat = 32'h5A5A5A5A;
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_addr2", 32'(obs_addr), 32'h21);
    tick();
    m_cyc = 1'b0; m_stb = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_acks", 32'(ack_cnt - a0), 32'd2);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
    chk("b2b_access_cnt", 32'(csb_low_q.size()), 32'd2);
    chk("b2b_access2_cyc", 32'(csb_low_q[1]), 32'(t0 + 5));
    rd(8'h21, 1, 32'h5A5A5A5A);
    rd(8'h20, 1, 32'hA5A5A5A5);

    // Reset held two cycles while the RL=3 instance is in WAIT
    tgt3 = 1'b1;
    tick();
    a0 = ack_cnt;
    start(1'b0, 4'hF, 8'hFF, 32'h0, 3, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
    tick();
    chk("mid_rst_csb", 32'(obs_csb), 32'd1);
    chk("mid_rst_web", 32'(obs_web), 32'd1);
    chk("mid_rst_ack", 32'(obs_ack), 32'd0);
    chk("mid_rst_dat", obs_dat, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_rst_no_ack", 32'(ack_cnt - a0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spell_sram_wb_bridge.md
Name: spell_sram_wb_bridge

Overview:
- Wishbone-classic slave that converts single-beat requests from the spell memory router into OpenRAM sky130 single-port (port 0) cycles.
- Sits directly downstream of the router's sram_cyc/stb/we/sel/addr/dat outputs and returns sram_dat_i/sram_ack_i to it.
- Handles OpenRAM active-low chip and write enables, byte write masks and configurable read latency.
- Generates a one-cycle registered ack.

Parameters:
- ADDR_WIDTH, 8, word address width (256 x 32-bit words).
- DATA_WIDTH, 32, data word width; the byte-mask width is DATA_WIDTH/8.
- READ_LATENCY, 1, number of WAIT cycles after the ACCESS cycle before ram_dout0 is sampled; legal range 1..3.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  strobe; a request is cyc & stb.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_sel_i  in  4  byte lane select.
- wb_adr_i  in  ADDR_WIDTH  word address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data; valid while wb_ack_o is high after a read.
- wb_ack_o  out  1  one-cycle transfer acknowledge.
- ram_csb0  out  1  OpenRAM chip select, active low.
- ram_web0  out  1  OpenRAM write enable, active low.
- ram_wmask0  out  DATA_WIDTH/8  byte write mask.
- ram_addr0  out  ADDR_WIDTH  RAM address.
- ram_din0  out  DATA_WIDTH  RAM write data.
- ram_dout0  in  DATA_WIDTH  RAM read data.

Behaviour:
- All outputs are registered.
- Reset values:
  - ram_csb0=1, ram_web0=1.
  - ram_wmask0=0, ram_addr0=0, ram_din0=0.
  - wb_ack_o=0, wb_dat_o=0.
  - State = IDLE.
- States: IDLE, ACCESS, WAIT, ACK, TURN.
- IDLE:
  - On wb_cyc_i & wb_stb_i, latch adr, dat, sel and we.
  - Drive ram_csb0=0, ram_web0=~we, ram_addr0=adr, ram_din0=dat.
  - Drive ram_wmask0=sel for writes and 0 for reads.
  - Go to ACCESS.
- ACCESS (exactly one cycle with ram_csb0 low):
  - Next cycle ram_csb0=1 and ram_web0=1.
  - Write: go to ACK.
  - Read: go to WAIT with the latency counter set to READ_LATENCY-1.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 0, register ram_dout0 into wb_dat_o and go to ACK.
- ACK:
  - wb_ack_o=1 for exactly one cycle, then go to TURN.
- TURN:
  - Mandatory single idle cycle with wb_ack_o=0. A request still asserted during TURN is not sampled.
  - Go to IDLE. A request still asserted in IDLE starts a new transaction.
- Latency, with request first seen in IDLE at cycle 0:
  - Write: ack high in cycle 2.
  - Read: ack high in cycle 2+READ_LATENCY (cycle 3 at the default).
  - Back-to-back transactions have a throughput of one per (ack cycle + 2) cycles.
- wb_dat_o holds the last read value through writes and idle cycles. It is updated only on read completion.
- Reads always return the full word. The upstream block selects the byte lane.
- A write with wb_sel_i=0 performs a RAM cycle with mask 0 (no bytes change) and is still acked.
- Abort (wb_cyc_i low while in ACCESS or WAIT):
  - The RAM cycle already issued completes.
  - No ack is generated and wb_dat_o is not updated.
  - The next state is TURN.
- Abort in ACK: ack is still driven for that cycle. The master ignores it.
- wb_stb_i low with wb_cyc_i high in IDLE: no action.
- Reset mid-operation:
  - All outputs take their reset values on the next edge; ram_csb0 returns high immediately.
  - No ack is issued for the interrupted transfer.
- Inputs are not required to stay stable after the IDLE sample cycle; the bridge uses only latched values.

Decomposition:
- Shared defines file (alongside the existing memory-type constants):
  - State encodings SramStIdle/Access/Wait/Ack/Turn as 3-bit constants.
  - SRAM geometry constants for address and data width.
- The latency counter is an inline 2-bit down-counter. No sub-module is needed; the block is a single FSM module.

Test Plan:
- Reset: assert reset for 2 cycles mid-read (state WAIT) -> next edge csb0=1, web0=1, ack=0, wb_dat_o=0; no ack follows.
- Full-word write: adr=0x05, dat=0xDEADBEEF, sel=0xF -> cycle 1 csb0=0, web0=0, wmask0=0xF, addr0=0x05, din0=0xDEADBEEF; ack in cycle 2 only.
- Byte write and readback: write adr=0x05, dat=0x11111111, sel=0x4, then read adr=0x05 (RAM model, READ_LATENCY=1) -> ack in cycle 3 of the read with wb_dat_o=0xDE11BEEF; wmask0=0 and web0=1 during the read ACCESS cycle.
- Latency parameter: READ_LATENCY=3, read adr=0xFF holding 0x12345678 -> ack exactly in cycle 5; wb_dat_o=0x12345678; csb0 low only in cycle 1.
- Abort and back-to-back:
  - Drop cyc during WAIT -> no ack; wb_dat_o keeps its previous value.
  - Hold stb high across two writes -> second ACCESS occurs 2 cycles after the first ack (TURN then IDLE); exactly two ack pulses.
